alu_pipe_acc: RTL and testbench
===============================

Name: alu_pipe_acc

Overview:
Parametrised pipelined ALU with a valid/ready handshake on both sides, an internal accumulator, status flags (carry, overflow, zero) and an optional saturating mode. It keeps the 3-bit opcode set of the team's existing ALU family. It sits between operand producers and the result consumer in the neural datapath, with a configurable depth and global stall.

Parameters:
NBITS, 16, operand/result data width in bits (>=4)
PIPE, 2, latency in cycles from input accept to out_valid (1..4)
SAT, 0, 1 = signed saturation on overflow for arithmetic opcodes

Ports:
clk  input  1  clock, rising edge
arst  input  1  reset, asynchronous, active-high; clears all state
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
A  input  NBITS  operand A, two's complement
B  input  NBITS  operand B, two's complement
opcode  input  3  operation select
acc_sel  input  1  1 = use the accumulator in place of A
acc_clr  input  1  synchronous accumulator clear
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result
Y  output  NBITS+1  result; Y[NBITS] equals co
co  output  1  carry out
ov  output  1  signed overflow
zf  output  1  Y[NBITS-1:0] == 0

Behaviour:
- Accept: a beat is accepted at a rising edge when in_valid and in_ready are both high. Output transfer happens when out_valid and out_ready are both high.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - During a stall every pipeline stage, the accumulator and all outputs hold.
  - Global stall only; bubbles are not compressed.
  - Throughput is one beat per cycle while out_ready = 1.
- Operand: opA = acc_sel ? acc : A, sampled at the accept edge.
- Opcode to (op2, cin):
  - 0: (B, 0) gives A+B
  - 1: (B, 1) gives A+B+1
  - 2: (~B, 0) gives A-B-1
  - 3: (~B, 1) gives A-B
  - 4: (0, 0) pass A
  - 5: (0, 1) gives A+1
  - 6: (all ones, 0) gives A-1
  - 7: (0, 0) pass A
- Sum: sum = {1'b0,opA} + {1'b0,op2} + cin, computed at NBITS+1 bits.
  - co = sum[NBITS] for opcodes 0-3, 5 and 6; co = 0 for opcodes 4 and 7.
  - ov = (opA[msb]==op2[msb]) & (sum[NBITS-1]!=opA[msb]) for opcodes 0-3, 5 and 6; ov = 0 for opcodes 4 and 7.
- Saturation (SAT=1 and ov=1): result low bits become 0x7FF..F when opA[msb]=0, or 0x80..0 when opA[msb]=1. ov is still reported. co is unchanged. zf is taken from the saturated value.
- Pipeline:
  - The result is computed combinationally from the accepted beat and registered into stage 1 at the accept edge.
  - Stages 2..PIPE are delay registers carrying {valid, Y, co, ov, zf}.
  - Outputs come from stage PIPE, so out_valid rises PIPE edges after the accept edge (PIPE=1: visible right after the accept edge).
- Accumulator: an NBITS-bit register.
  - At every accept edge it loads the final result low bits, saturated if applicable.
  - Back-to-back acc_sel beats therefore chain with no hazard.
  - acc_clr=1 at an edge clears acc, even during a stall.
  - If acc_clr coincides with an accept, the beat uses the old acc value and the clear wins the update (acc = 0).
- Reset (arst high): immediately forces all stage valids, Y, co, ov, zf and acc to 0.
  - out_valid = 0, so in_ready = 1 once arst drops.
  - Beats in flight are discarded, with no partial output.
- While out_valid=0, Y/co/ov/zf hold their last values; they carry no meaning.

Test Plan:
1. Assert arst asynchronously while 2 beats are in flight -> out_valid, Y and acc go to 0 without a clock edge; no stale beat appears after release.
2. NBITS=16, PIPE=2: A=0xFFFF, B=0x0001, op0 -> 2 cycles later Y=0x10000, co=1, zf=1, ov=0.
3. A=0x7FFF, B=0x0001, op0:
   - SAT=0 -> Y=0x08000, ov=1, co=0.
   - SAT=1 -> Y=0x07FFF, ov=1, zf=0.
4. op3 with A=5, B=5 -> Y=0x10000, co=1, zf=1. op3 with A=3, B=5 -> Y=0x0FFFE, co=0, ov=0.
5. Pulse acc_clr, then 3 consecutive beats with acc_sel=1, op5 -> Y=1, 2, 3 on consecutive cycles; acc=3. Then acc_clr together with an acc_sel op5 beat -> output 4, acc=0.
6. Stream 6 beats with in_valid held high; hold out_ready low for 3 cycles mid-stream -> in_ready low, Y stable during the stall; all 6 results arrive in order, none lost or duplicated.

Source files
------------

// File: rtl/alu_pipe_acc_if.sv
// Operand/result handshake bundle for alu_pipe_acc: valid/ready on the input
// beat and on the result beat, plus the operand and status fields.
interface alu_pipe_acc_if #(
  parameter int NBITS = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic [2:0]       opcode;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS:0]   Y;
  logic             co;
  logic             ov;
  logic             zf;

  modport master (
    output in_valid, A, B, opcode, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, Y, co, ov, zf
  );

  modport slave (
    input  in_valid, A, B, opcode, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, Y, co, ov, zf
  );
endinterface

// File: rtl/alu_pipe_acc.sv
// Pipelined 3-bit-opcode ALU with accumulator, carry/overflow/zero flags,
// optional signed saturation and a global output-driven stall.
module alu_pipe_acc #(
  parameter int NBITS = 16,
  parameter int PIPE  = 2,
  parameter int SAT   = 0
) (
  input logic          clk,
  input logic          arst,
  alu_pipe_acc_if.slave bus
);
  localparam int MSB = NBITS - 1;

  logic             w_stall;
  logic             w_accept;
  logic [NBITS-1:0] w_opa;
  logic [NBITS-1:0] w_op2;
  logic             w_cin;
  logic             w_arith;
  logic [NBITS:0]   w_sum;
  logic             w_co;
  logic             w_ov;
  logic [NBITS-1:0] w_low;
  logic             w_zf;

  logic             r_valid [PIPE];
  logic [NBITS-1:0] r_y     [PIPE];
  logic             r_co    [PIPE];
  logic             r_ov    [PIPE];
  logic             r_zf    [PIPE];
  logic [NBITS-1:0] r_acc;

  assign w_stall      = r_valid[PIPE-1] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;
  assign w_accept     = bus.in_valid & ~w_stall;
  assign w_opa        = bus.acc_sel ? r_acc : bus.A;

  always_comb begin
    w_op2   = '0;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    case (bus.opcode)
      3'd0: w_op2 = bus.B;
      3'd1: begin w_op2 = bus.B;  w_cin = 1'b1; end
      3'd2: w_op2 = ~bus.B;
      3'd3: begin w_op2 = ~bus.B; w_cin = 1'b1; end
      3'd5: w_cin = 1'b1;
      3'd6: w_op2 = '1;
      default: w_arith = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_opa} + {1'b0, w_op2} + {{NBITS{1'b0}}, w_cin};
  assign w_co  = w_arith & w_sum[NBITS];
  assign w_ov  = w_arith & (w_opa[MSB] == w_op2[MSB]) & (w_sum[MSB] != w_opa[MSB]);

  // Overflow can only happen with equal operand signs, so opA's sign picks the rail.
  always_comb begin
    w_low = w_sum[MSB:0];
    if (SAT != 0 && w_ov)
      w_low = w_opa[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
  end

  assign w_zf = ~|w_low;

  // Stage 0 data only loads on accept so bubbles carry the last beat's values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < PIPE; i++) begin
        r_valid[i] <= 1'b0;
        r_y[i]     <= '0;
        r_co[i]    <= 1'b0;
        r_ov[i]    <= 1'b0;
        r_zf[i]    <= 1'b0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= w_accept;
      if (w_accept) begin
        r_y[0]  <= w_low;
        r_co[0] <= w_co;
        r_ov[0] <= w_ov;
        r_zf[0] <= w_zf;
      end
      for (int i = 1; i < PIPE; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_y[i]     <= r_y[i-1];
        r_co[i]    <= r_co[i-1];
        r_ov[i]    <= r_ov[i-1];
        r_zf[i]    <= r_zf[i-1];
      end
    end
  end

  // Clear beats a coincident accept; it also acts while stalled.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      r_acc <= '0;
    else if (bus.acc_clr)
      r_acc <= '0;
    else if (w_accept)
      r_acc <= w_low;
  end

  assign bus.out_valid = r_valid[PIPE-1];
  assign bus.Y         = {r_co[PIPE-1], r_y[PIPE-1]};
  assign bus.co        = r_co[PIPE-1];
  assign bus.ov        = r_ov[PIPE-1];
  assign bus.zf        = r_zf[PIPE-1];
endmodule

// File: tb/tb_alu_pipe_acc.sv
// Scoreboard bench: two identical-latency instances, SAT=0 and SAT=1, share one
// stimulus stream; each has its own expected-result queue and accumulator model.
module tb_alu_pipe_acc;
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [2:0]  opcode = '0;
  logic        acc_sel = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [19:0] q0[$];
  logic [19:0] q1[$];
  logic [15:0] acc0 = '0;
  logic [15:0] acc1 = '0;

  alu_pipe_acc_if #(.NBITS(16)) bus0 ();
  alu_pipe_acc_if #(.NBITS(16)) bus1 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.A = A;                assign bus1.A = A;
  assign bus0.B = B;                assign bus1.B = B;
  assign bus0.opcode = opcode;      assign bus1.opcode = opcode;
  assign bus0.acc_sel = acc_sel;    assign bus1.acc_sel = acc_sel;
  assign bus0.acc_clr = acc_clr;    assign bus1.acc_clr = acc_clr;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  alu_pipe_acc #(.NBITS(16), .PIPE(2), .SAT(0)) dut0 (.clk(clk), .arst(arst), .bus(bus0));
  alu_pipe_acc #(.NBITS(16), .PIPE(2), .SAT(1)) dut1 (.clk(clk), .arst(arst), .bus(bus1));

  always #5 clk = ~clk;

  // Returns {Y[16], Y[15:0], co, ov, zf} from integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op, input bit sat);
    logic [15:0] op2;
    logic [15:0] low;
    int c, us, ss;
    bit arith, co, ov;
    arith = 1'b1; c = 0; op2 = '0;
    case (op)
      3'd0: op2 = b;
      3'd1: begin op2 = b; c = 1; end
      3'd2: op2 = ~b;
      3'd3: begin op2 = ~b; c = 1; end
      3'd5: c = 1;
      3'd6: op2 = 16'hFFFF;
      default: arith = 1'b0;
    endcase
    us = int'({16'h0, a}) + int'({16'h0, op2}) + c;
    ss = $signed({{16{a[15]}}, a}) + $signed({{16{op2[15]}}, op2}) + c;
    co = arith && (us > 65535);
    ov = arith && (ss > 32767 || ss < -32768);
    low = us[15:0];
    if (sat && ov) low = (ss > 0) ? 16'h7FFF : 16'h8000;
    return {co, low, co, ov, (low == 16'h0)};
  endfunction

  always @(negedge clk) begin
    logic [19:0] e;
    if (bus0.out_valid && bus0.out_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected got Y=%h (no beat expected)", bus0.Y);
      end else begin
        e = q0.pop_front();
        $display("sb0 Y=%h co=%b ov=%b zf=%b exp=%h", bus0.Y, bus0.co, bus0.ov, bus0.zf, e);
        if ({bus0.Y, bus0.co, bus0.ov, bus0.zf} !== e) begin
          errors++;
          $display("FAIL sb0_result got %h required %h", {bus0.Y, bus0.co, bus0.ov, bus0.zf}, e);
        end
      end
    end
    if (bus1.out_valid && bus1.out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected got Y=%h (no beat expected)", bus1.Y);
      end else begin
        e = q1.pop_front();
        $display("sb1 Y=%h co=%b ov=%b zf=%b exp=%h", bus1.Y, bus1.co, bus1.ov, bus1.zf, e);
        if ({bus1.Y, bus1.co, bus1.ov, bus1.zf} !== e) begin
          errors++;
          $display("FAIL sb1_result got %h required %h", {bus1.Y, bus1.co, bus1.ov, bus1.zf}, e);
        end
      end
    end
  end

  // Entered and left at posedge+1; pushes expectations at the negedge before the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input logic sel, input logic clr);
    logic [19:0] e0, e1;
    bit ok;
    ok = 1'b0;
    A = a; B = b; opcode = op; acc_sel = sel; acc_clr = clr; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus0.in_ready) begin ok = 1'b1; break; end
      if (clr) begin acc0 = '0; acc1 = '0; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stayed 0 required 1");
    end else begin
      e0 = model(sel ? acc0 : a, b, op, 1'b0);
      e1 = model(sel ? acc1 : a, b, op, 1'b1);
      q0.push_back(e0);
      q1.push_back(e1);
      acc0 = clr ? 16'h0 : e0[18:3];
      acc1 = clr ? 16'h0 : e1[18:3];
    end
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc0 = '0; acc1 = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.Y !== 17'h0 || bus0.co !== 1'b0 || bus0.ov !== 1'b0 || bus0.zf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b Y=%h co=%b ov=%b zf=%b required all 0",
               bus0.out_valid, bus0.Y, bus0.co, bus0.ov, bus0.zf);
    end
    @(posedge clk); #1;
    arst = 1'b0;
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", bus0.in_ready);
    end
    idle(2);
  endtask

  task automatic test_add_carry();
    send(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early out_valid got %b required 0", bus0.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.Y !== 17'h10000 || bus0.co !== 1'b1 || bus0.zf !== 1'b1 || bus0.ov !== 1'b0) begin
      errors++;
      $display("FAIL add_carry got v=%b Y=%h co=%b zf=%b ov=%b required 1 10000 1 1 0",
               bus0.out_valid, bus0.Y, bus0.co, bus0.zf, bus0.ov);
    end
    idle(3);
  endtask

  task automatic test_overflow_sat();
    send(16'h7FFF, 16'h0001, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus0.Y !== 17'h08000 || bus0.ov !== 1'b1 || bus0.co !== 1'b0) begin
      errors++;
      $display("FAIL ovf_nosat got Y=%h ov=%b co=%b required 08000 1 0", bus0.Y, bus0.ov, bus0.co);
    end
    checks++;
    if (bus1.Y !== 17'h07FFF || bus1.ov !== 1'b1 || bus1.zf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sat got Y=%h ov=%b zf=%b required 07FFF 1 0", bus1.Y, bus1.ov, bus1.zf);
    end
    send(16'h8000, 16'h8000, 3'd0, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 3'd3, 1'b0, 1'b0);
    idle(4);
  endtask

  task automatic test_sub();
    send(16'd5, 16'd5, 3'd3, 1'b0, 1'b0);
    send(16'd3, 16'd5, 3'd3, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (bus0.Y !== 17'h0FFFE || bus0.co !== 1'b0 || bus0.ov !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg got Y=%h co=%b ov=%b required 0FFFE 0 0", bus0.Y, bus0.co, bus0.ov);
    end
    idle(3);
  endtask

  task automatic test_acc_chain();
    send(16'h1234, 16'h0, 3'd4, 1'b0, 1'b0);
    pulse_clr();
    for (int i = 0; i < 3; i++) send(16'hAAAA, 16'h0, 3'd5, 1'b1, 1'b0);
    send(16'hAAAA, 16'h0, 3'd5, 1'b1, 1'b1);
    send(16'h5555, 16'h0, 3'd4, 1'b1, 1'b0);
    idle(4);
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    send(16'h0011, 16'h0022, 3'd0, 1'b0, 1'b0);
    send(16'h0033, 16'h0044, 3'd0, 1'b0, 1'b0);
    #2 arst = 1'b1;
    #1;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.Y !== 17'h0 || bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b Y=%h required 0 0", bus0.out_valid, bus0.Y);
    end
    q0.delete(); q1.delete();
    acc0 = '0; acc1 = '0;
    @(posedge clk); #1;
    arst = 1'b0;
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stale_after_reset got v=%b rdy=%b required 0 1", bus0.out_valid, bus0.in_ready);
    end
    send(16'h5555, 16'h0, 3'd4, 1'b1, 1'b0);
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [16:0] hold;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(i * 3 + 1), 16'(16'h0100 * i), 3'd0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_valid got %b required 1", bus0.out_valid);
        end
        out_ready = 1'b0;
        hold = bus0.Y;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (bus0.in_ready !== 1'b0 || bus0.Y !== hold || bus0.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold cyc %0d got rdy=%b Y=%h v=%b required 0 %h 1",
                     k, bus0.in_ready, bus0.Y, bus0.out_valid, hold);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(6);
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 24; i++)
          send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      end
      begin
        repeat (30) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    idle(6);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_carry();
    test_overflow_sat();
    test_sub();
    test_acc_chain();
    test_reset_inflight();
    test_back_to_back();
    test_random();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
